bit_scan_32: RTL and testbench

BIT_SCAN_32 -- requirements
Module: bit_scan_32

---
 rtl/bit_scan_32.sv | 80 ++++++++
 tb/tb_bit_scan_32.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bit_scan_32.sv
// bit_scan_32: iterative 32-bit leading/trailing zero counter, four bits per cycle
module bit_scan_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src,
    input  logic        dir,
    output logic        busy,
    output logic        done,
    output logic [5:0]  idx,
    output logic        zero
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t      state_q;
    logic [31:0] sr_q;
    logic [31:0] src_rev;
    logic [5:0]  cnt_q;
    logic [5:0]  idx_q;
    logic        zero_q;
    logic        busy_q;
    logic        done_q;
    logic [1:0]  pos;
    // MSB-first scans reuse the LSB-first datapath on the mirrored word
    always_comb begin
        for (int i = 0; i < 32; i++) src_rev[i] = src[31 - i];
    end
    // lowest set position within the current nibble
    always_comb begin
        pos = sr_q[0] ? 2'd0 : sr_q[1] ? 2'd1 : sr_q[2] ? 2'd2 : 2'd3;
    end
    // control FSM with registered outputs; a zero word can only be seen on the first scan cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q    <= dir ? src_rev : src;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (sr_q == '0) begin
                        idx_q   <= 6'd32;
                        zero_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (|sr_q[3:0]) begin
                        idx_q   <= cnt_q + {4'd0, pos};
                        zero_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 6'd4;
                        sr_q  <= {4'd0, sr_q[31:4]};
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign idx  = idx_q;
    assign zero = zero_q;
endmodule

// File: tb/tb_bit_scan_32.sv
// tb_bit_scan_32: scoreboard bench for bit_scan_32 with directed and random scans
module tb_bit_scan_32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [31:0] src = '0;
    logic        busy;
    logic        done;
    logic        zero;
    logic [5:0]  idx;
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int busy_cnt = 0;
    typedef struct { logic [5:0] idx; logic zero; int acc; int lat; } exp_t;
    exp_t sb[$];
    exp_t e;

    bit_scan_32 dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .src  (src),
        .dir  (dir),
        .busy (busy),
        .done (done),
        .idx  (idx),
        .zero (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] ref_tz(logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return 6'(i);
        return 6'd32;
    endfunction

    function automatic logic [5:0] ref_lz(logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return 6'(31 - i);
        return 6'd32;
    endfunction

    // monitor: pops the scoreboard on every done pulse and checks exclusivity every cycle
    always @(negedge clk) begin
        if (busy && done) chk("busy_done_exclusive", 1, 0);
        if (rst) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("idx", idx, e.idx);
                chk("zero", zero, e.zero);
                chk("latency", cyc - e.acc, e.lat);
                chk("busy_cycles", busy_cnt, e.lat - 1);
            end
            busy_cnt = 0;
        end
    end

    task automatic wait_dones(int n);
        int seen = 0;
        for (int i = 0; i < 12 * n && seen < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        if (seen < n) begin
            chk("done_timeout", seen, n);
            sb.delete();
        end
    endtask

    task automatic issue(logic [31:0] s, logic d, logic [5:0] ei, logic ez);
        int lat;
        lat = ez ? 2 : int'(ei) / 4 + 2;
        @(negedge clk);
        start = 1'b1;
        src   = s;
        dir   = d;
        sb.push_back('{ei, ez, cyc, lat});
        wait_dones(1);
        start = 1'b0;
        src   = ~s;
        dir   = ~d;
        @(negedge clk);
        chk("idx_hold", idx, ei);
        chk("zero_hold", zero, ez);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        logic        d;
        int          c;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", idx, 0);
        chk("rst_zero", zero, 0);
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        issue(32'h0000_0001, 1'b0, 6'd0, 1'b0);
        issue(32'h0000_0001, 1'b1, 6'd31, 1'b0);
        issue(32'h0000_0000, 1'b0, 6'd32, 1'b1);
        issue(32'h0000_0000, 1'b1, 6'd32, 1'b1);
        issue(32'h0010_0000, 1'b0, 6'd20, 1'b0);
        issue(32'h0010_0000, 1'b1, 6'd11, 1'b0);
        issue(32'h8000_0000, 1'b0, 6'd31, 1'b0);
        issue(32'hFFFF_FFFF, 1'b1, 6'd0, 1'b0);
        issue(32'h0000_0008, 1'b0, 6'd3, 1'b0);
        issue(32'h0000_0010, 1'b0, 6'd4, 1'b0);
        issue(32'h0000_F000, 1'b1, 6'd16, 1'b0);
        // start held high: a new accept every third cycle
        @(negedge clk);
        start = 1'b1;
        src   = 32'h8000_0000;
        dir   = 1'b1;
        c = cyc;
        for (int k = 0; k < 3; k++) sb.push_back('{6'd0, 1'b0, c + 3 * k, 2});
        wait_dones(3);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_no_extra", sb.size(), 0);
        // abort a scan with reset on its third scan cycle
        issue(32'h0000_0000, 1'b0, 6'd32, 1'b1);
        @(negedge clk);
        start = 1'b1;
        src   = 32'h0100_0000;
        dir   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_idx", idx, 0);
        chk("abort_zero", zero, 0);
        repeat (12) @(negedge clk);
        issue(32'h0100_0000, 1'b0, 6'd24, 1'b0);
        // random words of varied sparsity against reference counts
        for (int k = 0; k < 40; k++) begin
            s = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1) << $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) s = s & ~(s - 32'h1) | (s & 32'h8000_0000);
            d = 1'($urandom_range(0, 1));
            issue(s, d, d ? ref_lz(s) : ref_tz(s), s == 32'h0);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
